present_enc_ctrl: RTL and testbench

- Iterative PRESENT encryption engine controller.
- Accepts one job (plaintext, key, key-size select) on a valid/ready input channel and sequences the one-round-per-cycle datapath through 31 rounds.
- Applies final whitening with round key 32 and presents the ciphertext on a valid/ready output channel.
- Sits between the bus/DMA front end and the round datapath; the PRESENT-80 and PRESENT-128 key schedules share one state register.

---
 rtl/present_pkg.sv | 60 ++++++
 rtl/present_enc_ctrl_dp.sv | 37 +++
 rtl/present_enc_ctrl.sv | 118 +++++++++++
 tb/tb_present_enc_ctrl.sv | 281 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/present_pkg.sv
// Shared PRESENT definitions: S-box, bit permutation, round-key extraction
// and the controller state type.
package present_pkg;

  localparam int unsigned NROUNDS_MAX = 31;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } state_t;

  function automatic logic [3:0] sbox(input logic [3:0] x);
    logic [3:0] y;
    case (x)
      4'h0: y = 4'hC;
      4'h1: y = 4'h5;
      4'h2: y = 4'h6;
      4'h3: y = 4'hB;
      4'h4: y = 4'h9;
      4'h5: y = 4'h0;
      4'h6: y = 4'hA;
      4'h7: y = 4'hD;
      4'h8: y = 4'h3;
      4'h9: y = 4'hE;
      4'hA: y = 4'hF;
      4'hB: y = 4'h8;
      4'hC: y = 4'h4;
      4'hD: y = 4'h7;
      4'hE: y = 4'h1;
      default: y = 4'h2;
    endcase
    return y;
  endfunction

  function automatic logic [63:0] sbox_layer(input logic [63:0] x);
    logic [63:0] y;
    y = '0;
    for (int unsigned n = 0; n < 16; n++) begin
      y[6'(4 * n) +: 4] = sbox(x[6'(4 * n) +: 4]);
    end
    return y;
  endfunction

  // Bit i moves to position 16*i mod 63; bit 63 stays in place.
  function automatic logic [63:0] player(input logic [63:0] x);
    logic [63:0] y;
    y = '0;
    for (int unsigned i = 0; i < 63; i++) begin
      y[6'((i * 16) % 63)] = x[6'(i)];
    end
    y[63] = x[63];
    return y;
  endfunction

  function automatic logic [63:0] round_key(input logic [127:0] key, input logic k128);
    return k128 ? key[127:64] : key[79:16];
  endfunction

endpackage

// File: rtl/present_enc_ctrl_dp.sv
// Combinational PRESENT leaf datapath: one round of the state and the
// 80/128-bit key schedule steps.
module roundenc
  import present_pkg::*;
(
  input  logic [63:0] i_state,
  input  logic [63:0] i_rkey,
  output logic [63:0] o_state
);
  assign o_state = player(sbox_layer(i_state ^ i_rkey));
endmodule

module keyschedule
  import present_pkg::*;
(
  input  logic [79:0] i_key,
  input  logic [4:0]  i_rnd,
  output logic [79:0] o_key
);
  logic [79:0] w_rot;
  // Rotate left by 61 is the same as rotate right by 19.
  assign w_rot = {i_key[18:0], i_key[79:19]};
  assign o_key = {sbox(w_rot[79:76]), w_rot[75:20], w_rot[19:15] ^ i_rnd, w_rot[14:0]};
endmodule

module keyschedule128
  import present_pkg::*;
(
  input  logic [127:0] i_key,
  input  logic [4:0]   i_rnd,
  output logic [127:0] o_key
);
  logic [127:0] w_rot;
  assign w_rot = {i_key[66:0], i_key[127:67]};
  assign o_key = {sbox(w_rot[127:124]), sbox(w_rot[123:120]), w_rot[119:67],
                  w_rot[66:62] ^ i_rnd, w_rot[61:0]};
endmodule

// File: rtl/present_enc_ctrl.sv
// Iterative PRESENT-80/128 encryption controller: one round per cycle,
// valid/ready job input and ciphertext output.
module present_enc_ctrl
  import present_pkg::*;
#(
  parameter bit          SUPPORT_K128 = 1'b1,
  parameter int unsigned NROUNDS      = NROUNDS_MAX
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [63:0]  in_text,
  input  logic [127:0] in_key,
  input  logic         in_k128,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [63:0]  out_text,
  output logic         busy,
  output logic [4:0]   rnd_o
);

  localparam logic [4:0] LP_LAST = 5'(NROUNDS);

  state_t       r_fsm, w_fsm_nxt;
  logic [63:0]  r_state, r_out_text, w_state_nxt, w_rkey;
  logic [127:0] r_key, w_key_nxt, w_key128_nxt;
  logic [79:0]  w_key80_nxt;
  logic [4:0]   r_rnd;
  logic         r_k128, r_out_valid;
  logic         w_accept, w_last, w_load_k128;

  // DONE can hand off directly to the next job, so ready follows out_ready.
  assign in_ready    = ~rst & ((r_fsm == IDLE) | ((r_fsm == DONE) & out_ready));
  assign w_accept    = in_valid & in_ready;
  assign w_last      = (r_rnd == LP_LAST);
  assign w_load_k128 = in_k128 & SUPPORT_K128;

  assign w_rkey = round_key(r_key, r_k128);

  roundenc u_round (
    .i_state (r_state),
    .i_rkey  (w_rkey),
    .o_state (w_state_nxt)
  );

  keyschedule u_ks80 (
    .i_key (r_key[79:0]),
    .i_rnd (r_rnd),
    .o_key (w_key80_nxt)
  );

  generate
    if (SUPPORT_K128) begin : g_k128
      keyschedule128 u_ks128 (
        .i_key (r_key),
        .i_rnd (r_rnd),
        .o_key (w_key128_nxt)
      );
    end else begin : g_no_k128
      assign w_key128_nxt = '0;
    end
  endgenerate

  assign w_key_nxt = r_k128 ? w_key128_nxt : {48'b0, w_key80_nxt};

  always_ff @(posedge clk) begin
    if (rst) r_fsm <= IDLE;
    else     r_fsm <= w_fsm_nxt;
  end

  always_comb begin
    w_fsm_nxt = r_fsm;
    case (r_fsm)
      IDLE: if (w_accept) w_fsm_nxt = RUN;
      RUN:  if (w_last) w_fsm_nxt = DONE;
      DONE: begin
        if (w_accept)       w_fsm_nxt = RUN;
        else if (out_ready) w_fsm_nxt = IDLE;
      end
      default: w_fsm_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= '0;
      r_key       <= '0;
      r_k128      <= 1'b0;
      r_rnd       <= '0;
      r_out_text  <= '0;
      r_out_valid <= 1'b0;
    end else begin
      if ((r_fsm == DONE) && out_ready) r_out_valid <= 1'b0;
      if (w_accept) begin
        r_state <= in_text;
        r_key   <= w_load_k128 ? in_key : {48'b0, in_key[79:0]};
        r_k128  <= w_load_k128;
        r_rnd   <= 5'd1;
      end else if (r_fsm == RUN) begin
        r_state <= w_state_nxt;
        r_key   <= w_key_nxt;
        r_rnd   <= r_rnd + 5'd1;
        // Final whitening uses the key produced by this last schedule step.
        if (w_last) begin
          r_out_text  <= w_state_nxt ^ round_key(w_key_nxt, r_k128);
          r_out_valid <= 1'b1;
        end
      end
    end
  end

  assign out_valid = r_out_valid;
  assign out_text  = r_out_text;
  assign busy      = (r_fsm == RUN);
  assign rnd_o     = r_rnd;

endmodule

// File: tb/tb_present_enc_ctrl.sv
// Self-checking bench for present_enc_ctrl against a loop-based PRESENT
// reference model.
module tb_present_enc_ctrl;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic [63:0]  in_text = '0;
  logic [127:0] in_key = '0;
  logic         in_k128 = 1'b0;
  logic         out_valid;
  logic         out_ready = 1'b1;
  logic [63:0]  out_text;
  logic         busy;
  logic [4:0]   rnd_o;

  int n_checks = 0;
  int n_fail   = 0;

  present_enc_ctrl #(.SUPPORT_K128(1'b1), .NROUNDS(31)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_text   (in_text),
    .in_key    (in_key),
    .in_k128   (in_k128),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_text  (out_text),
    .busy      (busy),
    .rnd_o     (rnd_o)
  );

  always #5 clk = ~clk;

  function automatic logic [63:0] ref_enc(input logic [63:0] pt, input logic [127:0] key,
                                          input bit k128);
    int sb[16] = '{12, 5, 6, 11, 9, 0, 10, 13, 3, 14, 15, 8, 4, 7, 1, 2};
    logic [127:0] k, kn;
    logic [63:0]  s, t;
    int w, base;
    w = k128 ? 128 : 80;
    base = k128 ? 62 : 15;
    k = '0;
    for (int b = 0; b < w; b++) k[b] = key[b];
    s = pt;
    for (int r = 1; r <= 31; r++) begin
      for (int b = 0; b < 64; b++) t[b] = k[w - 64 + b];
      s = s ^ t;
      for (int n = 0; n < 16; n++) s[4*n +: 4] = 4'(sb[s[4*n +: 4]]);
      t = '0;
      for (int i = 0; i < 64; i++) t[16 * (i % 4) + i / 4] = s[i];
      s = t;
      kn = '0;
      for (int b = 0; b < w; b++) kn[(b + 61) % w] = k[b];
      k = kn;
      k[w-1 -: 4] = 4'(sb[k[w-1 -: 4]]);
      if (k128) k[w-5 -: 4] = 4'(sb[k[w-5 -: 4]]);
      for (int j = 0; j < 5; j++) k[base + j] = k[base + j] ^ r[j];
    end
    for (int b = 0; b < 64; b++) t[b] = k[w - 64 + b];
    return s ^ t;
  endfunction

  // Called at a negedge; returns at the negedge after the acceptance edge.
  task automatic start_job(input logic [63:0] t, input logic [127:0] k, input logic m,
                           output bit ok);
    int g = 0;
    in_text = t; in_key = k; in_k128 = m; in_valid = 1'b1;
    #1;
    while (!in_ready && g < 100) begin @(negedge clk); g++; end
    ok = in_ready;
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(negedge clk);
  endtask

  task automatic wait_out(output int cyc, output int busy_cnt);
    cyc = 0; busy_cnt = 0;
    while (!out_valid && cyc < 200) begin
      if (busy) busy_cnt++;
      @(negedge clk);
      cyc++;
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
    repeat (2) @(negedge clk);
    n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_out_valid got=%0b exp=0", out_valid); end
    n_checks++; if (out_text !== 64'h0) begin n_fail++; $display("FAIL reset_out_text got=%h exp=0", out_text); end
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy got=%0b exp=0", busy); end
    n_checks++; if (rnd_o !== 5'd0) begin n_fail++; $display("FAIL reset_rnd got=%0d exp=0", rnd_o); end
    n_checks++; if (in_ready !== 1'b0) begin n_fail++; $display("FAIL reset_in_ready_during_rst got=%0b exp=0", in_ready); end
    rst = 1'b0;
    #1;
    n_checks++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL reset_in_ready_after got=%0b exp=1", in_ready); end
    @(negedge clk);
  endtask

  task automatic test_vectors80();
    logic [63:0]  pts[4]  = '{64'h0, 64'h0, 64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF};
    logic [127:0] keys[4] = '{128'h0, 128'hFFFF_FFFF_FFFF_FFFF_FFFF, 128'h0,
                              128'hFFFF_FFFF_FFFF_FFFF_FFFF_FFFF_FFFF_FFFF};
    logic [63:0]  exps[4] = '{64'h5579C1387B228445, 64'hE72C46C0F5945049,
                              64'hA112FFC72F68417B, 64'h3333DCD3213210D2};
    bit ok; int cyc, bc;
    out_ready = 1'b1;
    for (int v = 0; v < 4; v++) begin
      start_job(pts[v], keys[v], 1'b0, ok);
      n_checks++; if (!ok) begin n_fail++; $display("FAIL v80_accept[%0d] in_ready=0 exp=1", v); end
      wait_out(cyc, bc);
      n_checks++; if (cyc != 31) begin n_fail++; $display("FAIL v80_latency[%0d] got=%0d exp=31", v, cyc); end
      n_checks++; if (bc != 31) begin n_fail++; $display("FAIL v80_busy_cycles[%0d] got=%0d exp=31", v, bc); end
      n_checks++; if (out_text !== exps[v]) begin n_fail++; $display("FAIL v80_known[%0d] got=%h exp=%h", v, out_text, exps[v]); end
      n_checks++; if (out_text !== ref_enc(pts[v], keys[v], 1'b0)) begin n_fail++; $display("FAIL v80_model[%0d] got=%h exp=%h", v, out_text, ref_enc(pts[v], keys[v], 1'b0)); end
      @(negedge clk);
      n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL v80_consumed[%0d] out_valid=%0b exp=0", v, out_valid); end
    end
  endtask

  task automatic test_k128();
    logic [63:0] exps[2] = '{64'h96DB702A2E6900AF, 64'h5579C1387B228445};
    bit ok; int cyc, bc;
    for (int v = 0; v < 2; v++) begin
      start_job(64'h0, 128'h0, (v == 0), ok);
      wait_out(cyc, bc);
      n_checks++; if (!ok || cyc != 31) begin n_fail++; $display("FAIL k128_latency[%0d] got=%0d exp=31", v, cyc); end
      n_checks++; if (out_text !== exps[v]) begin n_fail++; $display("FAIL k128_known[%0d] got=%h exp=%h", v, out_text, exps[v]); end
      @(negedge clk);
    end
  endtask

  task automatic test_random();
    logic [63:0] t; logic [127:0] k; logic m;
    bit ok; int cyc, bc;
    for (int v = 0; v < 6; v++) begin
      t = {$urandom, $urandom};
      k = {$urandom, $urandom, $urandom, $urandom};
      m = 1'($urandom_range(0, 1));
      start_job(t, k, m, ok);
      wait_out(cyc, bc);
      n_checks++; if (!ok || cyc != 31) begin n_fail++; $display("FAIL rand_latency[%0d] got=%0d exp=31", v, cyc); end
      n_checks++; if (out_text !== ref_enc(t, k, m)) begin n_fail++; $display("FAIL rand_model[%0d] k128=%0b got=%h exp=%h", v, m, out_text, ref_enc(t, k, m)); end
      @(negedge clk);
    end
  endtask

  task automatic test_backpressure();
    logic [63:0] t, held; logic [127:0] k;
    bit ok; int cyc, bc;
    t = {$urandom, $urandom}; k = {$urandom, $urandom, $urandom, $urandom};
    out_ready = 1'b0;
    start_job(t, k, 1'b0, ok);
    wait_out(cyc, bc);
    held = out_text;
    n_checks++; if (held !== ref_enc(t, k, 1'b0)) begin n_fail++; $display("FAIL bp_model got=%h exp=%h", held, ref_enc(t, k, 1'b0)); end
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      n_checks++; if (out_valid !== 1'b1 || out_text !== held) begin n_fail++; $display("FAIL bp_hold[%0d] valid=%0b text=%h exp=1 %h", i, out_valid, out_text, held); end
      n_checks++; if (in_ready !== 1'b0) begin n_fail++; $display("FAIL bp_in_ready[%0d] got=%0b exp=0", i, in_ready); end
    end
    out_ready = 1'b1;
    #1;
    n_checks++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL bp_ready_path got=%0b exp=1", in_ready); end
    @(posedge clk); #1;
    n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL bp_drop got=%0b exp=0", out_valid); end
    @(negedge clk);
  endtask

  task automatic test_back_to_back();
    logic [63:0] jt[3]; logic [127:0] jk[3]; logic jm[3];
    int acc_e[3] = '{default: 0};
    int out_e[3] = '{default: 0};
    int nacc = 0, nout = 0, e = 0;
    bit pend, ov; logic [63:0] ot, ex;
    for (int j = 0; j < 3; j++) begin
      jt[j] = {$urandom, $urandom};
      jk[j] = {$urandom, $urandom, $urandom, $urandom};
      jm[j] = 1'($urandom_range(0, 1));
    end
    out_ready = 1'b1;
    in_text = jt[0]; in_key = jk[0]; in_k128 = jm[0]; in_valid = 1'b1;
    while (nout < 3 && e < 200) begin
      #1;
      pend = in_valid && in_ready; ov = out_valid; ot = out_text;
      @(posedge clk); e++;
      if (ov) begin
        ex = ref_enc(jt[nout], jk[nout], jm[nout]);
        n_checks++; if (ot !== ex) begin n_fail++; $display("FAIL b2b_text[%0d] got=%h exp=%h", nout, ot, ex); end
        out_e[nout] = e; nout++;
      end
      if (pend && nacc < 3) begin
        acc_e[nacc] = e; nacc++;
        #1;
        if (nacc < 3) begin in_text = jt[nacc]; in_key = jk[nacc]; in_k128 = jm[nacc]; end
        else in_valid = 1'b0;
      end
      @(negedge clk);
    end
    in_valid = 1'b0;
    n_checks++; if (nout != 3) begin n_fail++; $display("FAIL b2b_count got=%0d exp=3", nout); end
    n_checks++; if (out_e[0] - acc_e[0] != 32) begin n_fail++; $display("FAIL b2b_first got=%0d exp=32", out_e[0] - acc_e[0]); end
    for (int j = 1; j < 3; j++) begin
      n_checks++; if (out_e[j] - out_e[j-1] != 32) begin n_fail++; $display("FAIL b2b_period[%0d] got=%0d exp=32", j, out_e[j] - out_e[j-1]); end
      n_checks++; if (acc_e[j] != out_e[j-1]) begin n_fail++; $display("FAIL b2b_same_edge[%0d] acc=%0d exp=%0d", j, acc_e[j], out_e[j-1]); end
    end
    @(negedge clk);
    n_checks++; if (out_valid !== 1'b0 || busy !== 1'b0) begin n_fail++; $display("FAIL b2b_idle valid=%0b busy=%0b exp=0 0", out_valid, busy); end
  endtask

  task automatic test_reset_mid();
    bit ok; int g = 0, stale = 0, cyc, bc;
    out_ready = 1'b1;
    start_job({$urandom, $urandom}, {$urandom, $urandom, $urandom, $urandom}, 1'b1, ok);
    while (rnd_o != 5'd15 && g < 40) begin @(negedge clk); g++; end
    n_checks++; if (rnd_o !== 5'd15) begin n_fail++; $display("FAIL rmid_reach_rnd got=%0d exp=15", rnd_o); end
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    n_checks++; if (out_valid !== 1'b0 || in_ready !== 1'b1) begin n_fail++; $display("FAIL rmid_after valid=%0b ready=%0b exp=0 1", out_valid, in_ready); end
    n_checks++; if (busy !== 1'b0 || rnd_o !== 5'd0) begin n_fail++; $display("FAIL rmid_idle busy=%0b rnd=%0d exp=0 0", busy, rnd_o); end
    for (int i = 0; i < 40; i++) begin
      if (out_valid) stale++;
      @(negedge clk);
    end
    n_checks++; if (stale != 0) begin n_fail++; $display("FAIL rmid_stale got=%0d exp=0", stale); end
    start_job(64'h0, 128'h0, 1'b0, ok);
    wait_out(cyc, bc);
    n_checks++; if (out_text !== 64'h5579C1387B228445) begin n_fail++; $display("FAIL rmid_fresh got=%h exp=5579c1387b228445", out_text); end
    @(negedge clk);
  endtask

  task automatic test_busy_ignore();
    logic [63:0] t; logic [127:0] k;
    bit ok; int g = 0;
    t = {$urandom, $urandom}; k = {$urandom, $urandom, $urandom, $urandom};
    out_ready = 1'b0;
    start_job(t, k, 1'b0, ok);
    while (!out_valid && g < 100) begin
      in_valid = 1'b1;
      in_text = {$urandom, $urandom};
      in_key = {$urandom, $urandom, $urandom, $urandom};
      in_k128 = 1'($urandom_range(0, 1));
      #1;
      n_checks++; if (in_ready !== 1'b0) begin n_fail++; $display("FAIL ign_in_ready[%0d] got=%0b exp=0", g, in_ready); end
      @(negedge clk);
      g++;
    end
    in_valid = 1'b0;
    n_checks++; if (out_valid !== 1'b1) begin n_fail++; $display("FAIL ign_timeout out_valid=%0b exp=1", out_valid); end
    n_checks++; if (out_text !== ref_enc(t, k, 1'b0)) begin n_fail++; $display("FAIL ign_text got=%h exp=%h", out_text, ref_enc(t, k, 1'b0)); end
    out_ready = 1'b1;
    @(negedge clk);
    n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL ign_consume got=%0b exp=0", out_valid); end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog simulation time limit reached");
    $fatal(1);
  end

  initial begin
    @(negedge clk);
    test_reset();
    test_vectors80();
    test_k128();
    test_random();
    test_backpressure();
    test_back_to_back();
    test_reset_mid();
    test_busy_ignore();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
